matrix_vec_loader: RTL
======================

Name: matrix_vec_loader

Overview:
- Upstream feeder for the pairwise 16-bit vector adder.
- Collects a serial stream of 16-bit elements over a valid/ready handshake.
- Packs ten elements into one 160-bit operand bus whose ten 16-bit slices drive adder inputs a1..a10.
- Holds that bus stable and presents it with out_valid until the consumer accepts it.

Parameters:
- DATA_W, 16, width of one element and of each adder operand.
- N_ELEM, 10, elements per vector; must be even and at least 2.
- CNT_W, 8, width of the completed-vector counter.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  DATA_W  element data.
- in_valid  input  1  element valid.
- in_ready  output  1  loader can accept an element.
- ops  output  N_ELEM*DATA_W  packed operands; first element accepted in [N_ELEM*DATA_W-1 -: DATA_W] (adder a1), last in [DATA_W-1:0] (adder a10).
- out_valid  output  1  ops holds a complete vector.
- out_ready  input  1  consumer accepts ops.
- vec_count  output  CNT_W  number of vectors handed off, modulo 2^CNT_W.

Behaviour:
- Reset behaviour:
  - Asynchronous on rst_n low.
  - On reset: ops=0, out_valid=0, vec_count=0, element index idx=0, state=LOAD, in_ready=1.
  - Reset mid-vector discards any partially loaded elements; ops returns to 0.
- States:
  - LOAD: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- LOAD transitions:
  - An element is accepted on a clk edge with in_valid and in_ready both high.
  - The accepted element is written to slot idx (slot 0 = MSB slice), then idx increments.
  - Acceptance at idx==N_ELEM-1: next state HOLD, idx resets to 0, out_valid high the following cycle.
  - in_valid low: no change.
- HOLD transitions:
  - ops is frozen; in_data and in_valid are ignored.
  - out_ready high: next state LOAD, vec_count increments and wraps 2^CNT_W-1 to 0.
  - out_ready low: stay in HOLD indefinitely.
- Latency and throughput:
  - out_valid rises one cycle after the N_ELEM-th acceptance.
  - With continuous valid and ready the minimum period is N_ELEM+1 cycles per vector (N_ELEM load cycles plus 1 hold cycle).
- Slots not yet written in the current vector keep their previous-vector value; only complete vectors are ever presented.
- in_ready is driven combinationally from state only, never from in_valid.
- No data transformation: element bits pass to their slice unchanged.

Optional Feature:
- Macro: MATRIX_VEC_LOADER_LAST_EN.
- Enabled:
  - Adds input in_last (1 bit, qualified by in_valid) and output err_len (1 bit, reset 0).
  - in_last accepted at idx<N_ELEM-1: all remaining slots of that vector are forced to 0, state goes to HOLD, err_len=0.
  - N_ELEM-th element accepted without in_last: vector is still presented and err_len=1.
  - err_len is updated at each entry into HOLD and is valid while out_valid is high.
- Disabled: neither port exists and vectors are delimited by count only.

Test Plan:
- Reset then stream 1..10 with continuous in_valid and out_ready=1 -> out_valid high on cycle 11, ops slices a1..a10 = 0x0001..0x000A, in_ready low for exactly 1 cycle, vec_count=1.
- Stream ten elements with out_ready=0 for 5 cycles, then 0xFFFF on in_data with in_valid=1 -> in_ready=0, ops unchanged, out_valid held 5 cycles; on release the next vector starts at slot 0.
- Random in_valid gaps (about 50% duty) over 20 vectors -> each ops equals the model's packed vector; vec_count=20.
- Assert rst_n low after 4 elements are accepted -> ops=0, out_valid=0 immediately; the next 10 elements form a clean vector with slot 0 = first post-reset element.
- Run 256 vectors with CNT_W=8 -> vec_count wraps to 0.
- Macro enabled: in_last on the 3rd element (0x0A, 0x0B, 0x0C) -> ops = 0x000A,0x000B,0x000C followed by seven zero slices, err_len=0. Ten elements without in_last -> err_len=1.

Source files
------------

// File: rtl/matrix_vec_loader.sv
// Serial-to-parallel operand loader: packs N_ELEM elements into one bus and holds it until accepted.
// Optional in_last/err_len framing is enabled by defining MATRIX_VEC_LOADER_LAST_EN.
module matrix_vec_loader #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned N_ELEM = 10,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
`ifdef MATRIX_VEC_LOADER_LAST_EN
  input  logic                       in_last,
  output logic                       err_len,
`endif
  output logic                       in_ready,
  output logic [N_ELEM*DATA_W-1:0]   ops,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CNT_W-1:0]           vec_count
);

  localparam int unsigned IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam int unsigned OPS_W = N_ELEM * DATA_W;

  localparam logic [0:0] LOAD = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]       state, state_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  logic [OPS_W-1:0] ops_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic             accept;
  logic             done;
`ifdef MATRIX_VEC_LOADER_LAST_EN
  logic             err_nx;
`endif

  // Handshake flags come straight from the state register
  assign in_ready  = (state == LOAD);
  assign out_valid = (state == HOLD);

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    ops_nx   = ops;
    cnt_nx   = vec_count;
    accept   = in_valid && (state == LOAD);
    done     = accept && (idx == IDX_W'(N_ELEM - 1));
`ifdef MATRIX_VEC_LOADER_LAST_EN
    err_nx   = err_len;
    done     = done || (accept && in_last);
`endif
    case (state)
      LOAD: begin
        if (accept) begin
          // Slot 0 is the MSB slice; an early in_last zero-fills the tail slots
          for (int i = 0; i < int'(N_ELEM); i++) begin
            if (idx == IDX_W'(i)) begin
              ops_nx[(int'(N_ELEM) - 1 - i) * int'(DATA_W) +: DATA_W] = in_data;
            end
`ifdef MATRIX_VEC_LOADER_LAST_EN
            else if (in_last && (IDX_W'(i) > idx)) begin
              ops_nx[(int'(N_ELEM) - 1 - i) * int'(DATA_W) +: DATA_W] = '0;
            end
`endif
          end
          if (done) begin
            state_nx = HOLD;
            idx_nx   = '0;
`ifdef MATRIX_VEC_LOADER_LAST_EN
            err_nx   = !in_last;
`endif
          end else begin
            idx_nx = idx + IDX_W'(1);
          end
        end
      end
      default: begin
        if (out_ready) begin
          state_nx = LOAD;
          cnt_nx   = vec_count + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      idx       <= '0;
      ops       <= '0;
      vec_count <= '0;
`ifdef MATRIX_VEC_LOADER_LAST_EN
      err_len   <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      ops       <= ops_nx;
      vec_count <= cnt_nx;
`ifdef MATRIX_VEC_LOADER_LAST_EN
      err_len   <= err_nx;
`endif
    end
  end

endmodule
